// File: rtl/serial_bus_slave.sv
// Serial bus memory slave. It shifts in an LSB-first address, then either shifts in a
// write word or returns the stored word serially. Completion is signalled by a one-cycle ack.
module serial_bus_slave #(
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic clock,
  input  logic rst,
  input  logic s_sel,
  input  logic m_valid,
  input  logic m_mode,
  input  logic m_wdata,
  output logic s_rdata,
  output logic s_rvalid,
  output logic s_ready,
  output logic s_ack
);

  localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
  localparam int unsigned MaxAd  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned MaxCnt = (MaxAd > READ_LATENCY) ? MaxAd : READ_LATENCY;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StAddr  = 3'd1;
  localparam logic [2:0] StWdata = 3'd2;
  localparam logic [2:0] StRwait = 3'd3;
  localparam logic [2:0] StRdata = 3'd4;
  localparam logic [2:0] StAck   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_shift, addr_next;
  logic [DATA_WIDTH-1:0] data_q, data_d, data_shift;
  logic [DATA_WIDTH-1:0] rsr_q, rsr_d, rd_word;
  logic                  mode_q, mode_d;
  logic                  rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;
  logic                  addr_done, load, mem_we, eff_mode;

  logic [DATA_WIDTH-1:0] mem [Depth];

  // Incoming bits enter at the MSB so that after a full word the first bit sits at bit 0.
  if (ADDR_WIDTH == 1) begin : g_addr_one
    assign addr_shift = m_wdata;
  end else begin : g_addr_many
    assign addr_shift = {m_wdata, addr_q[ADDR_WIDTH-1:1]};
  end

  if (DATA_WIDTH == 1) begin : g_data_one
    assign data_shift = m_wdata;
  end else begin : g_data_many
    assign data_shift = {m_wdata, data_q[DATA_WIDTH-1:1]};
  end

  // The read address must include the bit consumed on the same edge when READ_LATENCY is 0.
  assign addr_next = ((state_q == StIdle) || (state_q == StAddr)) ? addr_shift : addr_q;
  assign rd_word   = mem[addr_next];
  assign eff_mode  = (state_q == StIdle) ? m_mode : mode_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rsr_d     = rsr_q;
    mode_d    = mode_q;
    rdata_d   = 1'b0;
    rvalid_d  = 1'b0;
    ack_d     = 1'b0;
    mem_we    = 1'b0;
    addr_done = 1'b0;
    load      = 1'b0;

    case (state_q)
      StIdle: begin
        if (s_sel && m_valid) begin
          addr_d = addr_shift;
          mode_d = m_mode;
          cnt_d  = CntW'(1);
          if (ADDR_WIDTH == 1) begin
            addr_done = 1'b1;
          end else begin
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        if (m_valid) begin
          addr_d = addr_shift;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == CntW'(ADDR_WIDTH - 1)) begin
            addr_done = 1'b1;
          end
        end
      end
      StWdata: begin
        if (m_valid) begin
          data_d = data_shift;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
            mem_we  = 1'b1;
            ack_d   = 1'b1;
            cnt_d   = '0;
            state_d = StAck;
          end
        end
      end
      StRwait: begin
        if (cnt_q == CntW'(READ_LATENCY - 1)) begin
          load = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRdata: begin
        if (cnt_q == CntW'(DATA_WIDTH)) begin
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = StAck;
        end else begin
          rdata_d  = rsr_q[0];
          rsr_d    = rsr_q >> 1;
          rvalid_d = 1'b1;
          cnt_d    = cnt_q + CntW'(1);
        end
      end
      StAck: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase

    if (addr_done) begin
      cnt_d = '0;
      if (eff_mode) begin
        state_d = StWdata;
      end else if (READ_LATENCY == 0) begin
        load = 1'b1;
      end else begin
        state_d = StRwait;
      end
    end

    if (load) begin
      rdata_d  = rd_word[0];
      rsr_d    = rd_word >> 1;
      rvalid_d = 1'b1;
      cnt_d    = CntW'(1);
      state_d  = StRdata;
    end

    // Losing the select mid-transaction drops everything without touching memory.
    if ((state_q != StIdle) && !s_sel) begin
      state_d  = StIdle;
      cnt_d    = '0;
      rdata_d  = 1'b0;
      rvalid_d = 1'b0;
      ack_d    = 1'b0;
      mem_we   = 1'b0;
    end

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rsr_q    <= '0;
      mode_q   <= 1'b0;
      rdata_q  <= 1'b0;
      rvalid_q <= 1'b0;
      ready_q  <= 1'b1;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rsr_q    <= rsr_d;
      mode_q   <= mode_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ready_q  <= ready_d;
      ack_q    <= ack_d;
    end
  end

  // Storage is deliberately not reset; contents survive rst.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[addr_q] <= data_shift;
    end
  end

  assign s_rdata  = rdata_q;
  assign s_rvalid = rvalid_q;
  assign s_ready  = ready_q;
  assign s_ack    = ack_q;

endmodule

// File: tb/tb_serial_bus_slave.sv
// Directed bench for serial_bus_slave: a READ_LATENCY=2 instance plus a READ_LATENCY=0
// instance that share stimulus, selected by use_z.
module tb_serial_bus_slave;
  localparam int AW = 11;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;
  logic m_valid = 1'b0;
  logic m_mode = 1'b0;
  logic m_wdata = 1'b0;
  logic use_z = 1'b0;
  logic a_rdata, a_rvalid, a_ready, a_ack;
  logic z_rdata, z_rvalid, z_ready, z_ack;
  logic s_rdata, s_rvalid, s_ready, s_ack;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  assign s_rdata  = use_z ? z_rdata  : a_rdata;
  assign s_rvalid = use_z ? z_rvalid : a_rvalid;
  assign s_ready  = use_z ? z_ready  : a_ready;
  assign s_ack    = use_z ? z_ack    : a_ack;

  serial_bus_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) dut (
    .clock(clock), .rst(rst), .s_sel(sel & ~use_z), .m_valid(m_valid), .m_mode(m_mode),
    .m_wdata(m_wdata), .s_rdata(a_rdata), .s_rvalid(a_rvalid), .s_ready(a_ready),
    .s_ack(a_ack)
  );

  serial_bus_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(0)) dut0 (
    .clock(clock), .rst(rst), .s_sel(sel & use_z), .m_valid(m_valid), .m_mode(m_mode),
    .m_wdata(m_wdata), .s_rdata(z_rdata), .s_rvalid(z_rvalid), .s_ready(z_ready),
    .s_ack(z_ack)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives a full write; pos<0 disables the stall for that phase.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int sa_pos, input int sa_len, input int sd_pos,
                          input int sd_len, output logic ack_next, output logic ready_leak);
    ready_leak = 1'b0;
    sel = 1'b1;
    for (int i = 0; i < AW; i++) begin
      if (i == sa_pos) begin
        for (int j = 0; j < sa_len; j++) begin
          m_valid = 1'b0; m_wdata = ~addr[i]; m_mode = 1'b0;
          step();
          if (s_ready) ready_leak = 1'b1;
        end
      end
      m_valid = 1'b1; m_mode = (i == 0); m_wdata = addr[i];
      step();
      if (s_ready) ready_leak = 1'b1;
    end
    for (int i = 0; i < DW; i++) begin
      if (i == sd_pos) begin
        for (int j = 0; j < sd_len; j++) begin
          m_valid = 1'b0; m_wdata = ~data[i];
          step();
          if (s_ready) ready_leak = 1'b1;
        end
      end
      m_valid = 1'b1; m_mode = 1'b0; m_wdata = data[i];
      step();
      if (s_ready) ready_leak = 1'b1;
    end
    ack_next = s_ack;
    m_valid = 1'b0; m_wdata = 1'b0;
    step();
  endtask

  // Cycle k=1 is the cycle right after the edge consuming the last address bit.
  task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                         output int first, output int nvalid, output int ack_k);
    data = '0; first = -1; nvalid = 0; ack_k = -1;
    sel = 1'b1;
    for (int i = 0; i < AW; i++) begin
      m_valid = 1'b1; m_mode = (i != 0); m_wdata = addr[i];
      step();
    end
    m_valid = 1'b0; m_wdata = 1'b0; m_mode = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (s_rvalid) begin
        if (first < 0) first = k;
        if (nvalid < DW) data[nvalid[2:0]] = s_rdata;
        nvalid++;
      end
      if (s_ack) begin
        ack_k = k;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", s_ready); end
    checks++; if (s_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b want=0", s_rvalid); end
    checks++; if (s_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b want=0", s_ack); end
    checks++; if (s_rdata !== 1'b0) begin failures++; $display("FAIL reset_rdata got=%b want=0", s_rdata); end
    @(negedge clock);
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    logic ack, leak;
    logic [DW-1:0] d;
    int f, n, a;
    do_write(11'h123, 8'hA5, -1, 0, -1, 0, ack, leak);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wr_ack got=%b want=1", ack); end
    checks++; if (s_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_width got=%b want=0", s_ack); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL wr_ready_after got=%b want=1", s_ready); end
    do_read(11'h123, d, f, n, a);
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL rd_data got=%h want=a5", d); end
    checks++; if (f !== 3) begin failures++; $display("FAIL rd_first got=%0d want=3", f); end
    checks++; if (n !== 8) begin failures++; $display("FAIL rd_nvalid got=%0d want=8", n); end
    checks++; if (a !== 11) begin failures++; $display("FAIL rd_ack_cycle got=%0d want=11", a); end
  endtask

  task automatic test_stalled_write();
    logic ack, leak;
    logic [DW-1:0] d;
    int f, n, a;
    do_write(11'h7FF, 8'hA5, 5, 3, 4, 2, ack, leak);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL stall_ack got=%b want=1", ack); end
    checks++; if (leak !== 1'b0) begin failures++; $display("FAIL stall_ready_low got=%b want=0", leak); end
    do_read(11'h7FF, d, f, n, a);
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL stall_rd_data got=%h want=a5", d); end
    checks++; if (a !== 11) begin failures++; $display("FAIL stall_rd_ack got=%0d want=11", a); end
  endtask

  task automatic test_back_to_back();
    logic ack0, ack1, leak;
    logic [DW-1:0] d;
    int f, n, a;
    do_write(11'h000, 8'h3C, -1, 0, -1, 0, ack0, leak);
    do_write(11'h001, 8'hC3, -1, 0, -1, 0, ack1, leak);
    checks++; if (ack0 !== 1'b1) begin failures++; $display("FAIL b2b_ack0 got=%b want=1", ack0); end
    checks++; if (ack1 !== 1'b1) begin failures++; $display("FAIL b2b_ack1 got=%b want=1", ack1); end
    do_read(11'h000, d, f, n, a);
    checks++; if (d !== 8'h3C) begin failures++; $display("FAIL b2b_rd0 got=%h want=3c", d); end
    do_read(11'h001, d, f, n, a);
    checks++; if (d !== 8'hC3) begin failures++; $display("FAIL b2b_rd1 got=%h want=c3", d); end
  endtask

  task automatic test_abort();
    logic ack, leak, ack_seen;
    logic [DW-1:0] d;
    logic [AW-1:0] ad;
    int f, n, a;
    do_write(11'h010, 8'h11, -1, 0, -1, 0, ack, leak);
    ad = 11'h010;
    sel = 1'b1;
    for (int i = 0; i < AW; i++) begin
      m_valid = 1'b1; m_mode = (i == 0); m_wdata = ad[i];
      step();
    end
    for (int i = 0; i < 4; i++) begin
      m_valid = 1'b1; m_mode = 1'b0; m_wdata = 1'b1;
      step();
    end
    sel = 1'b0; m_valid = 1'b0;
    step();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b want=1", s_ready); end
    ack_seen = s_ack;
    for (int k = 0; k < 12; k++) begin
      step();
      if (s_ack) ack_seen = 1'b1;
    end
    checks++; if (ack_seen !== 1'b0) begin failures++; $display("FAIL abort_no_ack got=%b want=0", ack_seen); end
    do_read(11'h010, d, f, n, a);
    checks++; if (d !== 8'h11) begin failures++; $display("FAIL abort_mem got=%h want=11", d); end
  endtask

  task automatic test_reset_mid_read();
    logic ack, leak;
    logic [DW-1:0] d;
    logic [AW-1:0] ad;
    int f, n, a, cnt;
    do_write(11'h055, 8'hF8, -1, 0, -1, 0, ack, leak);
    ad = 11'h055;
    sel = 1'b1;
    for (int i = 0; i < AW; i++) begin
      m_valid = 1'b1; m_mode = 1'b0; m_wdata = ad[i];
      step();
    end
    m_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (s_rvalid) begin
        if (cnt == 3) break;
        cnt++;
      end
      step();
    end
    checks++; if (s_rdata !== 1'b1) begin failures++; $display("FAIL rstrd_bit3 got=%b want=1", s_rdata); end
    rst = 1'b1;
    #1;
    checks++; if (s_rvalid !== 1'b0) begin failures++; $display("FAIL rstrd_rvalid got=%b want=0", s_rvalid); end
    checks++; if (s_rdata !== 1'b0) begin failures++; $display("FAIL rstrd_rdata got=%b want=0", s_rdata); end
    checks++; if (s_ack !== 1'b0) begin failures++; $display("FAIL rstrd_ack got=%b want=0", s_ack); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rstrd_ready got=%b want=1", s_ready); end
    @(posedge clock);
    #2;
    rst = 1'b0;
    step();
    do_read(11'h055, d, f, n, a);
    checks++; if (d !== 8'hF8) begin failures++; $display("FAIL rstrd_mem got=%h want=f8", d); end
  endtask

  task automatic test_zero_latency();
    logic ack, leak;
    logic [DW-1:0] d;
    int f, n, a;
    use_z = 1'b1;
    do_write(11'h123, 8'h5A, -1, 0, -1, 0, ack, leak);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL rl0_wr_ack got=%b want=1", ack); end
    do_read(11'h123, d, f, n, a);
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL rl0_data got=%h want=5a", d); end
    checks++; if (f !== 1) begin failures++; $display("FAIL rl0_first got=%0d want=1", f); end
    checks++; if (n !== 8) begin failures++; $display("FAIL rl0_nvalid got=%0d want=8", n); end
    checks++; if (a !== 9) begin failures++; $display("FAIL rl0_ack_cycle got=%0d want=9", a); end
    use_z = 1'b0;
    sel = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_stalled_write();
    test_back_to_back();
    test_abort();
    test_reset_mid_read();
    test_zero_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
